// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional ISSUE watchdog with sticky timeout_err is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 uart_wr_en,
    output logic [7:0]           uart_data,
    input  logic                 uart_tx_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     bytes_sent,
    output logic                 timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_W < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of range");
    end

    // (base + offs) mod NUM_REQ; both operands are already below NUM_REQ.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offs);
        int sum;
        sum = int'({{(32-IW){1'b0}}, base}) + offs;
        sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
        return sum[IW-1:0];
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [1:0]         r_state,     w_state_nxt;
    logic [NUM_REQ-1:0] r_grant,     w_grant_nxt;
    logic [IW-1:0]      r_gidx,      w_gidx_nxt;
    logic [IW-1:0]      r_ptr,       w_ptr_nxt;
    logic [NUM_REQ-1:0] r_req_ready, w_req_ready_nxt;
    logic               r_wr_en,     w_wr_en_nxt;
    logic [7:0]         r_data,      w_data_nxt;
    logic               r_last,      w_last_nxt;
    logic               r_busy,      w_busy_nxt;
    logic [CNT_W-1:0]   r_bytes,     w_bytes_nxt;
    logic               w_found;
    logic [IW-1:0]      w_win;
    logic [7:0]         w_sel_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]      r_tcnt,      w_tcnt_nxt;
    logic               r_terr,      w_terr_nxt;
`endif

    assign w_sel_data = req_data[{r_gidx, 3'b000} +: 8];

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[wrap_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(r_ptr, k);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state and next-output computation for the packet FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_gidx_nxt      = r_gidx;
        w_ptr_nxt       = r_ptr;
        w_req_ready_nxt = '0;
        w_wr_en_nxt     = r_wr_en;
        w_data_nxt      = r_data;
        w_last_nxt      = r_last;
        w_bytes_nxt     = r_bytes;
`ifdef UART_ARB_TIMEOUT_EN
        w_tcnt_nxt      = r_tcnt;
        w_terr_nxt      = r_terr;
`endif
        case (r_state)
            S_IDLE: begin
                if (uart_tx_ready && w_found) begin
                    w_grant_nxt = onehot(w_win);
                    w_gidx_nxt  = w_win;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            S_FETCH: begin
                if (req_valid[r_gidx]) begin
                    w_data_nxt      = w_sel_data;
                    w_last_nxt      = req_last[r_gidx];
                    w_req_ready_nxt = r_grant;
                    w_wr_en_nxt     = 1'b1;
                    w_state_nxt     = S_ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
                    w_tcnt_nxt      = '0;
`endif
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_ISSUE: begin
                // The UART only samples wr_en on its baud tick, so hold until tx_ready falls.
                if (!uart_tx_ready) begin
                    w_wr_en_nxt = 1'b0;
                    w_bytes_nxt = r_bytes + CNT_W'(1);
                    w_state_nxt = S_DRAIN;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_wr_en_nxt = 1'b0;
                    w_terr_nxt  = 1'b1;
                    w_ptr_nxt   = wrap_idx(r_gidx, 1);
                    w_grant_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tcnt_nxt  = r_tcnt + TW'(1);
                end
`else
                else begin
                    w_wr_en_nxt = 1'b1;
                end
`endif
            end
            S_DRAIN: begin
                if (uart_tx_ready) begin
                    if (r_last) begin
                        w_ptr_nxt   = wrap_idx(r_gidx, 1);
                        w_grant_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_wr_en_nxt = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_ptr       <= '0;
            r_req_ready <= '0;
            r_wr_en     <= 1'b0;
            r_data      <= 8'h00;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_bytes     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_tcnt      <= '0;
            r_terr      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_gidx      <= w_gidx_nxt;
            r_ptr       <= w_ptr_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_data      <= w_data_nxt;
            r_last      <= w_last_nxt;
            r_busy      <= w_busy_nxt;
            r_bytes     <= w_bytes_nxt;
`ifdef UART_ARB_TIMEOUT_EN
            r_tcnt      <= w_tcnt_nxt;
            r_terr      <= w_terr_nxt;
`endif
        end
    end

    assign req_ready  = r_req_ready;
    assign grant      = r_grant;
    assign uart_wr_en = r_wr_en;
    assign uart_data  = r_data;
    assign busy       = r_busy;
    assign bytes_sent = r_bytes;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = r_terr;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
